// File: rtl/inv_sub_bytes_serial_if.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_serial_if
// Handshake bundle for the serial AES InvSubBytes unit.
//   in_valid  / in_ready  / in_data   : upstream state hand-off (128 bits)
//   out_valid / out_ready / out_data  : downstream result hand-off (128 bits)
// Modports:
//   slave  - the InvSubBytes unit itself
//   master - the surrounding datapath (upstream producer + downstream consumer)
// ---------------------------------------------------------------------------
interface inv_sub_bytes_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/inv_sub_bytes_serial.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_serial
// Sequential AES InvSubBytes: one shared inverse S-box, one byte per cycle,
// bytes 0 (LSB) through 15. A new state is accepted in IDLE, substituted over
// 16 BUSY cycles, then held in DONE until the consumer takes it.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of inv_sub_bytes_serial_if (valid/ready in and out)
// ---------------------------------------------------------------------------
module inv_sub_bytes_serial (
  input  logic                   clk,
  input  logic                   rst_n,
  inv_sub_bytes_serial_if.slave  bus
);

  // Inverse S-box, entry 0 in the most significant byte so that entry x sits
  // at bit offset 8*(255-x); 255-x for an 8-bit x is simply ~x.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         r_fsm;
  logic [3:0]   r_idx;
  logic [127:0] r_state;
  logic         r_in_ready;
  logic         r_out_valid;

  logic [7:0]   w_byte;
  logic [7:0]   w_inv;

  assign w_byte = r_state[{r_idx, 3'b000} +: 8];
  assign w_inv  = INV_SBOX[{~w_byte, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_idx       <= 4'd0;
      r_state     <= 128'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_state    <= bus.in_data;
            r_idx      <= 4'd0;
            r_fsm      <= BUSY;
            r_in_ready <= 1'b0;
          end
        end
        BUSY: begin
          r_state[{r_idx, 3'b000} +: 8] <= w_inv;
          r_idx <= r_idx + 4'd1;  // wraps to 0 after byte 15
          if (r_idx == 4'd15) begin
            r_fsm       <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // No same-cycle accept: in_ready only rises after the transfer.
          if (bus.out_ready) begin
            r_fsm       <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_state;

endmodule

// File: doc/inv_sub_bytes_serial.md
# inv_sub_bytes_serial

Sequential AES InvSubBytes unit for the decryption datapath. It accepts a 128-bit state through a valid/ready handshake and applies the FIPS-197 inverse S-box to all 16 bytes. It uses one shared inverse S-box, processing one byte per cycle. It holds the result until the downstream stage takes it. It is the inverse of the byte-wise forward SubBytes path and is sized for the Tiny Tapeout area budget.

## Interface
Parameters:
- None. The state width (128 bits) and byte count (16) are fixed.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream presents a state on in_data.
- in_ready  output  1  block can accept a state.
- in_data  input  128  ciphertext-side state; byte k = in_data[8k+7:8k].
- out_valid  output  1  out_data holds a completed InvSubBytes result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  result state; byte k = InvS(in byte k).

## Operation
- Internal resources:
  - 128-bit state register, driven directly to out_data.
  - 4-bit byte index.
  - FSM with states IDLE, BUSY, DONE.
- Inverse S-box:
  - Combinational 256-entry lookup per FIPS-197 Fig. 14, as a local submodule or case table.
  - Anchor values: InvS(00)=52, InvS(01)=09, InvS(63)=00, InvS(7C)=01, InvS(ED)=53, InvS(FF)=7D, InvS(16)=FF.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1 at a clock edge: state register takes in_data, index clears to 0, FSM moves to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge, byte[index] is replaced by InvS(byte[index]) and index increments.
  - At the edge where index=15, byte 15 is written, index wraps to 0, and the FSM moves to DONE.
  - in_valid is ignored while BUSY.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data is held stable regardless of in_valid.
  - When out_ready=1 at a clock edge, the FSM moves to IDLE. There is no same-cycle accept of a new input in DONE.
- Each byte is substituted exactly once per transaction. Processing order is byte 0 (LSB) to byte 15.
- No other illegal state is reachable. Any unencoded FSM value returns to IDLE on the next edge.

## Timing
- Reset (rst_n=0, asynchronous, immediate):
  - FSM=IDLE, index=0, state register=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0.
- Latency:
  - Acceptance edge E0; bytes 0..15 are substituted at edges E1..E16.
  - out_valid is high in the cycle after E16, i.e. 16 cycles after acceptance.
- Hand-off timing:
  - Output transfer edge D0 → in_ready=1 in the next cycle.
  - Earliest next acceptance is the edge after D0.
  - Minimum period is 18 cycles per block with out_ready tied high.
- Backpressure: out_valid stays high and out_data is unchanged for any number of cycles with out_ready=0.
- Upstream rules: in_data is sampled only on the acceptance edge. in_data may change freely at all other times.
- Reset mid-operation (BUSY or DONE):
  - The partial or complete result is discarded and outputs return to their reset values immediately.
  - After rst_n deasserts, the first edge with in_valid=1 is a fresh acceptance.
- While BUSY, out_data shows the partially substituted state. Downstream must qualify out_data with out_valid.

## Test plan
- Reset values: assert rst_n=0 mid-cycle → in_ready=1, out_valid=0, out_data=0 immediately, without waiting for a clock edge.
- Known vectors:
  - in_data=all bytes 63 → out_data=all 00.
  - in_data=all 00 → all 52.
  - in_data=all FF → all 7D.
  - For each, out_valid rises exactly 16 cycles after acceptance.
- Mixed/order: in_data bytes 0..15 = 63,7C,00,01,ED,16,FF,63,… → out bytes = 00,01,52,09,53,FF,7D,00,… in the same positions. Also feed FS(x) for 16 random x (software model) and check x is recovered.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_data stable and in_ready=0 throughout. Toggle in_valid and in_data during this time; they have no effect.
- Back-to-back: keep in_valid=1 and out_ready=1 with two different states → both results are correct, and the second acceptance occurs exactly 2 cycles after out_valid first rises (18-cycle period).
- Reset mid-BUSY: pulse rst_n low at cycle 8 after acceptance → out_valid never rises for that block. The next accepted all-63 state yields all 00.
